enigma_step_ctrl: RTL

Sequencing and stepping controller for the three-rotor scrambler. Accepts plaintext letters and rotor start-position loads on a valid/ready input port. It issues per-rotor `en`/`load`/`inc` controls with correct Enigma double-step behaviour, and drives the letter into the scrambler path entry. It captures the returned letter once the path has settled and presents it on a valid/ready output port. It sits directly upstream of the rotor chain and is the only block that drives rotor controls.

---
 rtl/enigma_pkg.sv | 31 +++
 rtl/enigma_step_decode.sv | 20 ++
 rtl/enigma_step_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/enigma_pkg.sv
// Shared types, constants and helpers for the Enigma rotor datapath and its controller.
package enigma_pkg;

    localparam int NUM_LETTERS = 26;

    typedef logic [4:0] letter_t;

    localparam int ROT_R = 0;
    localparam int ROT_M = 1;
    localparam int ROT_L = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STEP   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_OUT    = 3'd4
    } state_t;

    // A 5-bit value never exceeds 31, so one conditional subtract reduces it to 0..25.
    function automatic letter_t mod26(input letter_t value);
        letter_t reduced;
        if (value >= letter_t'(NUM_LETTERS)) begin
            reduced = value - letter_t'(NUM_LETTERS);
        end else begin
            reduced = value;
        end
        return reduced;
    endfunction

endpackage

// File: rtl/enigma_step_decode.sv
// Double-step decode: turns pre-step turnover flags of the right and middle rotors
// into per-rotor increment requests.
module enigma_step_decode
    import enigma_pkg::*;
(
    input  logic [1:0] turnover,
    output logic [2:0] inc
);

    // The right rotor always steps; the middle rotor steps when the right one turns
    // over or when it sits on its own notch (the double step); the left rotor steps
    // only when the middle rotor is at its notch.
    always_comb begin
        inc        = 3'b000;
        inc[ROT_R] = 1'b1;
        inc[ROT_M] = turnover[ROT_R] | turnover[ROT_M];
        inc[ROT_L] = turnover[ROT_M];
    end

endmodule

// File: rtl/enigma_step_ctrl.sv
// Sequencing and stepping controller for the three-rotor scrambler: takes letters
// and rotor start-position loads, drives rotor controls, and returns the cipher letter.
module enigma_step_ctrl
    import enigma_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_load,
    input  logic [4:0] in_char,
    input  logic [2:0] turnover,
    output logic [2:0] rotor_en,
    output logic [2:0] rotor_load,
    output logic [2:0] rotor_inc,
    output logic [2:0] ld_sel,
    output logic [4:0] ld_char,
    output logic [4:0] enc_char,
    input  logic [4:0] ret_char,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_char,
    output logic       out_err
);

    state_t     state;
    state_t     state_next;
    letter_t    char_reg;
    logic [1:0] slot;
    logic [2:0] step_inc;
    logic       accept;

    // The left rotor's turnover flag has no consumer: nothing sits left of it.
    logic unused_left_turnover;
    assign unused_left_turnover = turnover[ROT_L];

    assign accept = (state == ST_IDLE) && in_valid;

    enigma_step_decode u_decode (
        .turnover (turnover[1:0]),
        .inc      (step_inc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; out-of-range letters skip stepping and go straight to output.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (in_load) begin
                        state_next = ST_LOAD;
                    end else if (in_char < letter_t'(NUM_LETTERS)) begin
                        state_next = ST_STEP;
                    end else begin
                        state_next = ST_OUT;
                    end
                end
            end
            ST_LOAD:   state_next = ST_IDLE;
            ST_STEP:   state_next = ST_SETTLE;
            ST_SETTLE: state_next = ST_OUT;
            ST_OUT: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default:   state_next = ST_IDLE;
        endcase
    end

    // Output decode; rotor controls are only ever asserted in LOAD and STEP.
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        rotor_en   = 3'b000;
        rotor_load = 3'b000;
        rotor_inc  = 3'b000;
        ld_sel     = 3'b000;
        ld_char    = '0;
        unique case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_LOAD: begin
                ld_sel     = 3'b001 << slot;
                rotor_en   = 3'b001 << slot;
                rotor_load = 3'b001 << slot;
                ld_char    = mod26(char_reg);
            end
            ST_STEP: begin
                rotor_inc = step_inc;
                rotor_en  = step_inc;
            end
            ST_OUT: begin
                out_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Input letter register; it also feeds the scrambler path entry at all times.
    always_ff @(posedge clk) begin
        if (rst) begin
            char_reg <= '0;
        end else if (accept) begin
            char_reg <= in_char;
        end
    end

    assign enc_char = char_reg;

    // Load slot pointer walks right, middle, left and wraps back to the right rotor.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot <= 2'd0;
        end else if (state == ST_LOAD) begin
            slot <= (slot == 2'd2) ? 2'd0 : slot + 2'd1;
        end
    end

    // Result register: captured at the end of SETTLE, or directly from the input
    // for an out-of-range letter, and frozen while the result waits in OUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_char <= '0;
            out_err  <= 1'b0;
        end else if (state == ST_SETTLE) begin
            out_char <= ret_char;
            out_err  <= 1'b0;
        end else if (accept && !in_load && (in_char >= letter_t'(NUM_LETTERS))) begin
            out_char <= in_char;
            out_err  <= 1'b1;
        end
    end

endmodule
